mcpu_alu_seq: RTL and testbench
===============================

MCPU_ALU_SEQ -- requirements
Module: mcpu_alu_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of every data and ALU port.
REQ-002 SHALL have derived localparam SW = $clog2(DATA_WIDTH), the width of the shift count field.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: command request, sampled only in IDLE.
REQ-006 SHALL have port cmd, input, 2 bits: 00 MUL, 01 SHL, 10 SHR, 11 reserved.
REQ-007 SHALL have port opa, input, DATA_WIDTH: first operand (multiplicand, or the value to shift).
REQ-008 SHALL have port opb, input, DATA_WIDTH: second operand (multiplier, or shift count in opb[SW-1:0]).
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: high for exactly one cycle, in state DONE.
REQ-011 SHALL have port result, output, DATA_WIDTH: the accumulator register, held until the next accepted start.
REQ-012 SHALL have port alu_op, output, DATA_WIDTH: op word driven to the shared ALU; bits above 6 are always 0.
REQ-013 SHALL have ports alu_a and alu_b, output, DATA_WIDTH each: the ALU A and B operands.
REQ-014 SHALL have port alu_d, input, DATA_WIDTH: the ALU data result, used in the same cycle it is produced (the ALU is combinational).

Function
REQ-015 SHALL implement FSM states IDLE, ADD, SHL, SHR, SHIFT and DONE.
REQ-016 SHALL, in IDLE, drive alu_op=0, alu_a=0 and alu_b=0.
REQ-017 SHALL accept start in IDLE for cmd=MUL as: acc<=0, mcand<=opa, mult<=opb; then next state = DONE if opb==0, else ADD if opb[0]==1, else SHL.
REQ-018 SHALL, in ADD, drive alu_op=0x00 (ADD, B pass), alu_a=acc, alu_b=mcand; then acc<=alu_d and next state = SHL.
REQ-019 SHALL, in SHL, drive alu_op=0x65 (pass B, left shift), alu_b=mcand; then mcand<=alu_d and next state = SHR.
REQ-020 SHALL, in SHR, drive alu_op=0x45 (pass B, right shift), alu_b=mult; then mult<=alu_d and next state = DONE if alu_d==0, else ADD if alu_d[0]==1, else SHL.
REQ-021 SHALL produce the MUL result as the low DATA_WIDTH bits of opa*opb (unsigned); overflow bits are discarded and no overflow flag exists.
REQ-022 SHALL accept start in IDLE for cmd=SHL/SHR as: acc<=opa, cnt<=opb[SW-1:0]; then next state = DONE if that count is 0, else SHIFT.
REQ-023 SHALL, in SHIFT, drive alu_op=0x65 for SHL or 0x45 for SHR, alu_b=acc; then acc<=alu_d, cnt<=cnt-1, and next state = DONE when cnt==1.
REQ-024 SHALL give a shift by n (n>0) done exactly n+1 cycles after the start edge.
REQ-025 SHALL treat start with cmd=11 as: acc<=opa, then DONE next cycle (no ALU activity).
REQ-026 SHALL, in DONE, assert done, keep busy high and drive ALU outputs to 0; next state = IDLE unconditionally.
REQ-027 SHALL ignore start while busy, and SHALL NOT change acc, mcand, mult or cnt when start is ignored.
REQ-028 SHALL ignore opa, opb and cmd in every state other than IDLE; the operands are captured only at accept.
REQ-029 SHALL make a start asserted in the cycle after DONE (state IDLE) accepted normally; back-to-back commands need no dead cycle beyond DONE.

Reset
REQ-030 SHALL, on reset high at a clock edge, set state=IDLE, busy=0, done=0, acc/result=0, mcand=0, mult=0 and cnt=0.
REQ-031 SHALL give reset priority over start and over every FSM transition, including mid-operation.
REQ-032 SHALL, after reset mid-operation, produce no done pulse and accept a new start in the first cycle after reset is released.

Verification
REQ-033 SHALL cover reset: hold reset 2 cycles -> busy=0, done=0, result=0, alu_op=0.
REQ-034 SHALL cover 6*7: MUL opa=6, opb=7 -> state sequence ADD,SHL,SHR three times, done in cycle 10 after the start edge, result=42.
REQ-035 SHALL cover zero multiplier: MUL opa=5, opb=0 -> done in cycle 1, result=0; also 0xFFFFFFFF*0xFFFFFFFF -> result=1.
REQ-036 SHALL cover shifts: SHL opa=1, opb=31 -> done in cycle 32, result=0x80000000; SHR opa=0x80000000, opb=0 -> done in cycle 1, result=0x80000000.
REQ-037 SHALL cover busy start: start with new operands while busy during MUL 3*5 -> ignored, result=15.
REQ-038 SHALL cover reset mid-operation: reset asserted in cycle 4 of a MUL -> busy=0, no done pulse, and the next start completes correctly.

Source files
------------

// File: rtl/mcpu_alu_seq.sv
// Sequential multiply / multi-cycle shift controller that time-shares an
// external combinational ALU; one command runs at a time, result held in acc.
module mcpu_alu_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cmd,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_d
);
  localparam int SW = $clog2(DATA_WIDTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADD   = 3'd1;
  localparam logic [2:0] ST_SHL   = 3'd2;
  localparam logic [2:0] ST_SHR   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam logic [1:0] CMD_MUL = 2'b00;
  localparam logic [1:0] CMD_SHL = 2'b01;
  localparam logic [1:0] CMD_SHR = 2'b10;

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SHL = 7'h65;
  localparam logic [6:0] OP_SHR = 7'h45;

  logic [2:0]            state_reg, state_next;
  logic [DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [DATA_WIDTH-1:0] mcand_reg, mcand_next;
  logic [DATA_WIDTH-1:0] mult_reg, mult_next;
  logic [SW-1:0]         cnt_reg, cnt_next;
  logic                  dir_reg, dir_next;   // 1 = right shift in ST_SHIFT
  logic [6:0]            op_next;
  logic [DATA_WIDTH-1:0] a_next, b_next;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    mult_next  = mult_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    op_next    = OP_ADD;
    a_next     = '0;
    b_next     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          case (cmd)
            CMD_MUL: begin
              acc_next   = '0;
              mcand_next = opa;
              mult_next  = opb;
              if (opb == '0)    state_next = ST_DONE;
              else if (opb[0])  state_next = ST_ADD;
              else              state_next = ST_SHL;
            end
            CMD_SHL, CMD_SHR: begin
              acc_next   = opa;
              cnt_next   = opb[SW-1:0];
              dir_next   = (cmd == CMD_SHR);
              state_next = (opb[SW-1:0] == '0) ? ST_DONE : ST_SHIFT;
            end
            default: begin
              acc_next   = opa;
              state_next = ST_DONE;
            end
          endcase
        end
      end
      ST_ADD: begin
        op_next    = OP_ADD;
        a_next     = acc_reg;
        b_next     = mcand_reg;
        acc_next   = alu_d;
        state_next = ST_SHL;
      end
      ST_SHL: begin
        op_next    = OP_SHL;
        b_next     = mcand_reg;
        mcand_next = alu_d;
        state_next = ST_SHR;
      end
      ST_SHR: begin
        // Branch on the freshly shifted multiplier, not the stale register.
        op_next   = OP_SHR;
        b_next    = mult_reg;
        mult_next = alu_d;
        if (alu_d == '0)    state_next = ST_DONE;
        else if (alu_d[0])  state_next = ST_ADD;
        else                state_next = ST_SHL;
      end
      ST_SHIFT: begin
        op_next  = dir_reg ? OP_SHR : OP_SHL;
        b_next   = acc_reg;
        acc_next = alu_d;
        cnt_next = cnt_reg - SW'(1);
        if (cnt_reg == SW'(1)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      mcand_reg <= '0;
      mult_reg  <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      mult_reg  <= mult_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
    end
  end

  assign busy   = (state_reg != ST_IDLE);
  assign done   = (state_reg == ST_DONE);
  assign result = acc_reg;
  assign alu_op = {{(DATA_WIDTH-7){1'b0}}, op_next};
  assign alu_a  = a_next;
  assign alu_b  = b_next;
endmodule

// File: tb/tb_mcpu_alu_seq.sv
// Directed bench for mcpu_alu_seq with a behavioural model of the shared ALU.
module tb_mcpu_alu_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [31:0] opa = '0, opb = '0;
  logic        busy, done;
  logic [31:0] result, alu_op, alu_a, alu_b, alu_d;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mcpu_alu_seq #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_d(alu_d)
  );

  // Shared ALU: ADD, pass-B left shift by one, pass-B right shift by one.
  always_comb begin
    case (alu_op)
      32'h00:  alu_d = alu_a + alu_b;
      32'h65:  alu_d = alu_b << 1;
      32'h45:  alu_d = alu_b >> 1;
      default: alu_d = '0;
    endcase
  end

  task automatic run_cmd(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output logic [31:0] res);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; cmd = c; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0; opa = 32'hDEADBEEF; opb = 32'h12345677; cmd = 2'b01;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) cyc = -1;
    res = result;
    $display("cmd=%0d opa=%08h opb=%08h -> result=%08h done_cycle=%0d", c, a, b, res, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %08h expected 00000000", result); end
    vectors++; if (alu_op !== 32'h0) begin miscompares++; $display("FAIL reset_alu_op: got %08h expected 00000000", alu_op); end
    vectors++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin miscompares++; $display("FAIL reset_alu_ab: got %08h/%08h expected 0/0", alu_a, alu_b); end
    $display("reset applied: busy=%b done=%b result=%08h", busy, done, result);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul_6x7();
    logic [31:0] exp_ops [3];
    exp_ops[0] = 32'h00; exp_ops[1] = 32'h65; exp_ops[2] = 32'h45;
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; opa = 32'd6; opb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; opa = 32'hFFFF0000; opb = 32'h0000FFFF;
    for (int k = 1; k <= 9; k++) begin
      vectors++;
      if (alu_op !== exp_ops[(k-1)%3] || done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL mul6x7_seq: cycle %0d got op=%0h done=%b busy=%b expected op=%0h done=0 busy=1",
                 k, alu_op, done, busy, exp_ops[(k-1)%3]);
      end
      @(posedge clk); #1;
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mul6x7_done: got %b expected 1 at cycle 10", done); end
    vectors++; if (result !== 32'd42) begin miscompares++; $display("FAIL mul6x7_result: got %0d expected 42", result); end
    vectors++; if (alu_op !== 32'h0) begin miscompares++; $display("FAIL mul6x7_done_op: got %0h expected 0", alu_op); end
    $display("cmd=0 opa=6 opb=7 -> result=%0d done=%b", result, done);
  endtask

  task automatic test_zero_and_wrap();
    int cyc;
    logic [31:0] res;
    run_cmd(2'b00, 32'd5, 32'd0, cyc, res);
    vectors++; if (cyc != 1) begin miscompares++; $display("FAIL mul_zero_cycle: got %0d expected 1", cyc); end
    vectors++; if (res !== 32'h0) begin miscompares++; $display("FAIL mul_zero_result: got %08h expected 0", res); end
    run_cmd(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, res);
    vectors++; if (cyc != 97) begin miscompares++; $display("FAIL mul_ones_cycle: got %0d expected 97", cyc); end
    vectors++; if (res !== 32'h1) begin miscompares++; $display("FAIL mul_ones_result: got %08h expected 00000001", res); end
  endtask

  task automatic test_shifts();
    int cyc;
    logic [31:0] res;
    run_cmd(2'b01, 32'h1, 32'd31, cyc, res);
    vectors++; if (cyc != 32) begin miscompares++; $display("FAIL shl31_cycle: got %0d expected 32", cyc); end
    vectors++; if (res !== 32'h80000000) begin miscompares++; $display("FAIL shl31_result: got %08h expected 80000000", res); end
    run_cmd(2'b10, 32'h80000000, 32'd0, cyc, res);
    vectors++; if (cyc != 1) begin miscompares++; $display("FAIL shr0_cycle: got %0d expected 1", cyc); end
    vectors++; if (res !== 32'h80000000) begin miscompares++; $display("FAIL shr0_result: got %08h expected 80000000", res); end
    run_cmd(2'b10, 32'h000000F0, 32'hFFFFFFE4, cyc, res);
    vectors++; if (cyc != 5) begin miscompares++; $display("FAIL shr4_cycle: got %0d expected 5", cyc); end
    vectors++; if (res !== 32'h0000000F) begin miscompares++; $display("FAIL shr4_result: got %08h expected 0000000F", res); end
    run_cmd(2'b11, 32'h00001234, 32'd9, cyc, res);
    vectors++; if (cyc != 1) begin miscompares++; $display("FAIL reserved_cycle: got %0d expected 1", cyc); end
    vectors++; if (res !== 32'h00001234) begin miscompares++; $display("FAIL reserved_result: got %08h expected 00001234", res); end
  endtask

  task automatic test_busy_start();
    int cyc;
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1'b1; cmd = 2'b00; opa = 32'd3; opb = 32'd5;
    @(posedge clk); #1;
    cmd = 2'b01; opa = 32'h0000FFFF; opb = 32'd9;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 4) start = 1'b0;
    end
    start = 1'b0;
    vectors++; if (cyc != 9) begin miscompares++; $display("FAIL busy_start_cycle: got %0d expected 9", cyc); end
    vectors++; if (result !== 32'd15) begin miscompares++; $display("FAIL busy_start_result: got %0d expected 15", result); end
    $display("cmd=0 opa=3 opb=5 with start held while busy -> result=%0d done_cycle=%0d", result, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] res;
    run_cmd(2'b00, 32'd9, 32'd10, cyc, res);
    vectors++; if (res !== 32'd90) begin miscompares++; $display("FAIL b2b_first: got %0d expected 90", res); end
    // run_cmd starts at the next negedge with busy low, i.e. the cycle right after DONE.
    run_cmd(2'b01, 32'h0000000F, 32'd4, cyc, res);
    vectors++; if (res !== 32'h000000F0 || cyc != 5) begin
      miscompares++; $display("FAIL b2b_second: got %08h/%0d expected 000000F0/5", res, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1'b1; cmd = 2'b00; opa = 32'd6; opb = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_state: got busy=%b done=%b expected 0/0", busy, done); end
    vectors++; if (result !== 32'h0 || alu_op !== 32'h0) begin miscompares++; $display("FAIL midreset_regs: got result=%08h op=%0h expected 0/0", result, alu_op); end
    reset = 1'b0;
    start = 1'b1; cmd = 2'b00; opa = 32'd4; opb = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL midreset_accept: got busy=%b done=%b expected 1/0", busy, done); end
    cyc = 1;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    vectors++; if (seen_done != 0) begin miscompares++; $display("FAIL midreset_no_done: got %0d pulses expected 0", seen_done); end
    vectors++; if (cyc != 7 || result !== 32'd12) begin
      miscompares++; $display("FAIL midreset_next: got cycle=%0d result=%0d expected 7/12", cyc, result);
    end
    $display("reset mid-MUL then cmd=0 opa=4 opb=3 -> result=%0d done_cycle=%0d", result, cyc);
  endtask

  initial begin
    test_reset();
    test_mul_6x7();
    test_zero_and_wrap();
    test_shifts();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
